// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage between execute and register write-back.
//
// Captures the execute stage's ALU results, condition result and memory/write-back controls,
// then runs up to two sequential req/ack data-bus transactions (slot 1, then slot 2). Upstream
// is stalled while a transaction is outstanding. One registered write-back bundle is
// presented per accepted instruction, marked by a one-cycle out_valid_o strobe.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, a misaligned LW (addr[1:0] != 0) or
// LHU/LHS/SH (addr[0] == 1) skips its bus access, returns 0 in that slot, and raises fault_o
// with wb_op_o forced to 0. When undefined, fault_o stays 0 and low address bits are ignored.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   in_valid_i               execute outputs valid this cycle
//   r1_i, r2_i               ALU results (store data / pass-through values)
//   cres_i                   condition result; 0 squashes the instruction
//   m_a1_i, m_a2_i           slot 1/2 byte addresses
//   m_r1_op_i, m_r2_op_i     slot 1/2 memory ops
//   r_a1_i, r_a2_i, r_op_i   write-back register numbers and op
//   stall_o                  upstream must hold its inputs
//   out_valid_o              write-back bundle strobe
//   wb_d1_o, wb_d2_o         slot results
//   wb_a1_o, wb_a2_o, wb_op_o registered write-back controls
//   fault_o                  misaligned access in this bundle
//   bus_*                    req/ack data bus (word address, little-endian byte enables)
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [31:0] r1_i,
  input  logic [31:0] r2_i,
  input  logic        cres_i,
  input  logic [31:0] m_a1_i,
  input  logic [31:0] m_a2_i,
  input  logic [3:0]  m_r1_op_i,
  input  logic [3:0]  m_r2_op_i,
  input  logic [4:0]  r_a1_i,
  input  logic [4:0]  r_a2_i,
  input  logic [3:0]  r_op_i,
  output logic        stall_o,
  output logic        out_valid_o,
  output logic [31:0] wb_d1_o,
  output logic [31:0] wb_d2_o,
  output logic [4:0]  wb_a1_o,
  output logic [4:0]  wb_a2_o,
  output logic [3:0]  wb_op_o,
  output logic        fault_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [3:0] OpLw  = 4'b0001;
  localparam logic [3:0] OpLhu = 4'b0010;
  localparam logic [3:0] OpLbu = 4'b0011;
  localparam logic [3:0] OpLhs = 4'b0100;
  localparam logic [3:0] OpLbs = 4'b0101;
  localparam logic [3:0] OpSw  = 4'b1000;
  localparam logic [3:0] OpSh  = 4'b1001;
  localparam logic [3:0] OpSb  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2} state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OpLw) || (op == OpLhu) || (op == OpLbu) || (op == OpLhs) || (op == OpLbs);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OpSw) || (op == OpSh) || (op == OpSb);
  endfunction

  function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] lane,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OpLhu:   return {16'h0, h};
      OpLhs:   return {{16{h[15]}}, h};
      OpLbu:   return {24'h0, b};
      OpLbs:   return {{24{b[7]}}, b};
      default: return rdata;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
    return ((op == OpLw) && (lane != 2'b00)) ||
           (((op == OpLhu) || (op == OpLhs) || (op == OpSh)) && lane[0]);
  endfunction
`endif

  state_e      state_q, state_d;
  logic [3:0]  op1_q, op1_d, op2_q, op2_d;
  logic [31:0] a1_q, a1_d, a2_q, a2_d;
  logic        acc2_q, acc2_d;
  logic [31:0] wb_d1_q, wb_d1_d, wb_d2_q, wb_d2_d;
  logic [4:0]  wb_a1_q, wb_a1_d, wb_a2_q, wb_a2_d;
  logic [3:0]  wb_op_q, wb_op_d;
  logic        fault_q, fault_d;
  logic        out_valid_q, out_valid_d;

  logic        mis1, mis2, acc1_in, acc2_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis1 = misaligned(m_r1_op_i, m_a1_i[1:0]);
  assign mis2 = misaligned(m_r2_op_i, m_a2_i[1:0]);
`else
  assign mis1 = 1'b0;
  assign mis2 = 1'b0;
`endif

  assign acc1_in = (is_load(m_r1_op_i) || is_store(m_r1_op_i)) && !mis1;
  assign acc2_in = (is_load(m_r2_op_i) || is_store(m_r2_op_i)) && !mis2;

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    acc2_d      = acc2_q;
    wb_d1_d     = wb_d1_q;
    wb_d2_d     = wb_d2_q;
    wb_a1_d     = wb_a1_q;
    wb_a2_d     = wb_a2_q;
    wb_op_d     = wb_op_q;
    fault_d     = fault_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          op1_d   = m_r1_op_i;
          op2_d   = m_r2_op_i;
          a1_d    = m_a1_i;
          a2_d    = m_a2_i;
          wb_a1_d = r_a1_i;
          wb_a2_d = r_a2_i;
          acc2_d  = cres_i && acc2_in;
          if (!cres_i) begin
            wb_d1_d     = '0;
            wb_d2_d     = '0;
            wb_op_d     = '0;
            fault_d     = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            // wb_dX doubles as store data during the access; loads overwrite it on ack.
            wb_d1_d = mis1 ? '0 : r1_i;
            wb_d2_d = mis2 ? '0 : r2_i;
            fault_d = mis1 || mis2;
            wb_op_d = (mis1 || mis2) ? 4'h0 : r_op_i;
            if (acc1_in)      state_d = StAcc1;
            else if (acc2_in) state_d = StAcc2;
            else              out_valid_d = 1'b1;
          end
        end
      end
      StAcc1: begin
        if (bus_ack_i) begin
          if (is_load(op1_q)) wb_d1_d = load_data(op1_q, a1_q[1:0], bus_rdata_i);
          if (acc2_q) begin
            state_d = StAcc2;
          end else begin
            state_d     = StIdle;
            out_valid_d = 1'b1;
          end
        end
      end
      StAcc2: begin
        if (bus_ack_i) begin
          if (is_load(op2_q)) wb_d2_d = load_data(op2_q, a2_q[1:0], bus_rdata_i);
          state_d     = StIdle;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op1_q       <= '0;
      op2_q       <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      acc2_q      <= 1'b0;
      wb_d1_q     <= '0;
      wb_d2_q     <= '0;
      wb_a1_q     <= '0;
      wb_a2_q     <= '0;
      wb_op_q     <= '0;
      fault_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      acc2_q      <= acc2_d;
      wb_d1_q     <= wb_d1_d;
      wb_d2_q     <= wb_d2_d;
      wb_a1_q     <= wb_a1_d;
      wb_a2_q     <= wb_a2_d;
      wb_op_q     <= wb_op_d;
      fault_q     <= fault_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bus signals decode from state and captured operands only, so they stay constant until ack
  // and drop as soon as the asynchronous reset clears the state.
  logic [3:0]  cur_op;
  logic [31:0] cur_addr, cur_data;

  always_comb begin
    cur_op      = op1_q;
    cur_addr    = a1_q;
    cur_data    = wb_d1_q;
    if (state_q == StAcc2) begin
      cur_op   = op2_q;
      cur_addr = a2_q;
      cur_data = wb_d2_q;
    end
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    if (state_q != StIdle) begin
      bus_req_o  = 1'b1;
      bus_addr_o = {cur_addr[31:2], 2'b00};
      bus_be_o   = 4'hF;
      if (is_store(cur_op)) begin
        bus_we_o = 1'b1;
        unique case (cur_op)
          OpSb: begin
            bus_be_o    = 4'b0001 << cur_addr[1:0];
            bus_wdata_o = {4{cur_data[7:0]}};
          end
          OpSh: begin
            bus_be_o    = cur_addr[1] ? 4'b1100 : 4'b0011;
            bus_wdata_o = {2{cur_data[15:0]}};
          end
          default: bus_wdata_o = cur_data;
        endcase
      end
    end
  end

  assign stall_o     = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign wb_d1_o     = wb_d1_q;
  assign wb_d2_o     = wb_d2_q;
  assign wb_a1_o     = wb_a1_q;
  assign wb_a2_o     = wb_a2_q;
  assign wb_op_o     = wb_op_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cases then randomized instructions. A
// byte-level memory model predicts each write-back bundle and each bus transaction; a bus
// slave process serves the DUT and checks transactions, a monitor checks bundles.
module tb_mem_access_stage;

  localparam logic [3:0] OpNone = 4'h0, OpLw = 4'h1, OpLhu = 4'h2, OpLbu = 4'h3, OpLhs = 4'h4;
  localparam logic [3:0] OpLbs = 4'h5, OpSw = 4'h8, OpSh = 4'h9, OpSb = 4'hA;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid, cres, stall, out_valid, fault, bus_req, bus_we, bus_ack;
  logic [31:0] r1, r2, m_a1, m_a2, wb_d1, wb_d2, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  m_r1_op, m_r2_op, r_op, wb_op, bus_be;
  logic [4:0]  r_a1, r_a2, wb_a1, wb_a2;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .r1_i(r1), .r2_i(r2), .cres_i(cres),
    .m_a1_i(m_a1), .m_a2_i(m_a2), .m_r1_op_i(m_r1_op), .m_r2_op_i(m_r2_op), .r_a1_i(r_a1),
    .r_a2_i(r_a2), .r_op_i(r_op), .stall_o(stall), .out_valid_o(out_valid), .wb_d1_o(wb_d1),
    .wb_d2_o(wb_d2), .wb_a1_o(wb_a1), .wb_a2_o(wb_a2), .wb_op_o(wb_op), .fault_o(fault),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r1, r2, a1, a2;
    logic [3:0]  op1, op2, rop;
    logic [4:0]  ra1, ra2;
    logic        cres;
  } insn_t;
  typedef struct {
    logic [31:0] d1, d2;
    logic [4:0]  a1, a2;
    logic [3:0]  op;
    logic        fault;
    int          due;
  } exp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  exp_t exp_q[$];
  txn_t bus_q[$];
  logic [7:0]  mbytes[logic [31:0]];   // model memory, byte granular
  logic [31:0] smem[logic [31:0]];     // slave memory, word granular
  int n_chk = 0, n_pass = 0;
  int ack_delay = -1;                  // <0: random ack latency

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (mbytes.exists(a)) return mbytes[a];
    return 8'(init_word(a & ~32'h3) >> (8 * (a % 4)));
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    smem[wa] = v;
    for (int j = 0; j < 4; j++) mbytes[wa + 32'(j)] = v[8*j +: 8];
  endtask

  // One slot of the reference: byte-level memory semantics in program order.
  task automatic model_slot(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r,
                            output logic [31:0] d, inout logic flt, inout int nbus);
    int size;
    logic sgn, st;
    logic [31:0] base, v;
    txn_t t;
    size = 0; sgn = 1'b0; st = 1'b0;
    case (op)
      OpLw:  size = 4;
      OpLhu: size = 2;
      OpLhs: begin size = 2; sgn = 1'b1; end
      OpLbu: size = 1;
      OpLbs: begin size = 1; sgn = 1'b1; end
      OpSw:  begin size = 4; st = 1'b1; end
      OpSh:  begin size = 2; st = 1'b1; end
      OpSb:  begin size = 1; st = 1'b1; end
      default: size = 0;
    endcase
    d = r;
    if (size == 0) return;
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == OpLw && addr % 4 != 0) || (size == 2 && addr % 2 != 0)) begin
      d = '0;
      flt = 1'b1;
      return;
    end
`endif
    base = addr & ~32'(size - 1);
    nbus++;
    t.addr = base & ~32'h3;
    if (!st) begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(mbyte(base + 32'(i))) << (8 * i));
      if (sgn && v[8*size-1]) v = v | (~32'h0 << (8 * size));
      d = v;
      t.we = 1'b0; t.be = 4'hF; t.wdata = '0;
    end else begin
      t.we = 1'b1; t.be = '0;
      for (int i = 0; i < size; i++) begin
        mbytes[base + 32'(i)] = r[8*i +: 8];
        t.be[int'((base + 32'(i)) % 4)] = 1'b1;
      end
      for (int j = 0; j < 4; j++) t.wdata[8*j +: 8] = r[8*(j % size) +: 8];
    end
    bus_q.push_back(t);
  endtask

  function automatic insn_t mk(input logic [3:0] op1, input logic [31:0] a1,
                               input logic [31:0] v1, input logic [3:0] op2,
                               input logic [31:0] a2, input logic [31:0] v2, input logic c);
    insn_t x;
    x.op1 = op1; x.a1 = a1; x.r1 = v1; x.op2 = op2; x.a2 = a2; x.r2 = v2; x.cres = c;
    x.rop = 4'h7; x.ra1 = 5'd3; x.ra2 = 5'd4;
    return x;
  endfunction

  // Present one instruction once stall is low; lat > 0 pins the bundle latency.
  task automatic issue(input insn_t x, input int lat);
    int g;
    int nbus;
    logic flt;
    exp_t e;
    g = 0;
    while (stall && g < 300) begin @(negedge clk); g++; end
    if (stall) begin fail("issue_stall_timeout"); return; end
    in_valid = 1'b1; r1 = x.r1; r2 = x.r2; m_a1 = x.a1; m_a2 = x.a2; cres = x.cres;
    m_r1_op = x.op1; m_r2_op = x.op2; r_op = x.rop; r_a1 = x.ra1; r_a2 = x.ra2;
    nbus = 0; flt = 1'b0;
    if (!x.cres) begin
      e.d1 = '0; e.d2 = '0; e.op = '0; e.fault = 1'b0;
    end else begin
      model_slot(x.op1, x.a1, x.r1, e.d1, flt, nbus);
      model_slot(x.op2, x.a2, x.r2, e.d2, flt, nbus);
      e.op = flt ? 4'h0 : x.rop;
      e.fault = flt;
    end
    e.a1 = x.ra1; e.a2 = x.ra2;
    e.due = (nbus == 0) ? cyc + 1 : (lat > 0 ? cyc + lat : -1);
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: pops and compares one expected bundle per out_valid strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) fail("unexpected_out_valid");
        else begin
          e = exp_q.pop_front();
          check("wb_d1", wb_d1, e.d1);
          check("wb_d2", wb_d2, e.d2);
          check("wb_a1", 32'(wb_a1), 32'(e.a1));
          check("wb_a2", 32'(wb_a2), 32'(e.a2));
          check("wb_op", 32'(wb_op), 32'(e.op));
          check("fault", 32'(fault), 32'(e.fault));
          if (e.due >= 0) check("latency_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Bus slave: acks after a chosen number of waiting cycles, checks each transaction.
  initial begin
    int cnt;
    txn_t t;
    logic [31:0] w;
    cnt = -1;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (rst) cnt = -1;
      else if (bus_req) begin
        if (cnt < 0) cnt = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          if (bus_q.size() == 0) fail("unexpected_bus_req");
          else begin
            t = bus_q.pop_front();
            check("bus_we", 32'(bus_we), 32'(t.we));
            check("bus_addr", bus_addr, t.addr);
            check("bus_be", 32'(bus_be), 32'(t.be));
            if (t.we) check("bus_wdata", bus_wdata, t.wdata);
          end
          w = smem.exists(bus_addr) ? smem[bus_addr] : init_word(bus_addr);
          if (bus_we) begin
            for (int j = 0; j < 4; j++) if (bus_be[j]) w[8*j +: 8] = bus_wdata[8*j +: 8];
            smem[bus_addr] = w;
          end else bus_rdata = w;
          bus_ack = 1'b1;
          cnt = -1;
        end else cnt--;
      end else begin
        cnt = -1;
        // Stray acks while idle must be ignored.
        if ($urandom_range(0, 7) == 0) begin bus_ack = 1'b1; bus_rdata = $urandom; end
      end
    end
  end

  initial begin
    insn_t x;
    logic [3:0] ops[11];
    int g;
    ops = '{OpNone, OpLw, OpLhu, OpLbu, OpLhs, OpLbs, OpSw, OpSh, OpSb, 4'h6, 4'hF};
    in_valid = 1'b0; r1 = '0; r2 = '0; m_a1 = '0; m_a2 = '0; cres = 1'b0;
    m_r1_op = '0; m_r2_op = '0; r_op = '0; r_a1 = '0; r_a2 = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_wb_op", 32'(wb_op), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_wb_d1", wb_d1, 32'd0);
    rst = 1'b0;

    // Reset while slot 1 is waiting for ack.
    ack_delay = 1000;
    issue(mk(OpLw, 32'h100, 32'h0, OpNone, 32'h0, 32'h0, 1'b1), -1);
    @(negedge clk);
    check("acc1_bus_req", 32'(bus_req), 32'd1);
    check("acc1_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_bus_req", 32'(bus_req), 32'd0);
    exp_q.delete();
    bus_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Pass-through, back to back.
    ack_delay = -1;
    issue(mk(OpNone, 32'h0, 32'h12345678, OpNone, 32'h0, 32'hCAFEF00D, 1'b1), -1);
    check("b2b_no_stall", 32'(stall), 32'd0);
    issue(mk(OpNone, 32'h0, 32'h0BADBEEF, 4'hC, 32'h0, 32'h00000042, 1'b1), -1);

    // LBS at 0x1003, ack two cycles after req.
    preload(32'h1000, 32'h80FFFFFF);
    ack_delay = 2;
    issue(mk(OpLbs, 32'h1003, 32'h0, OpNone, 32'h0, 32'h0, 1'b1), 4);

    // SH then LW with immediate acks.
    preload(32'h3000, 32'hDEADBEEF);
    ack_delay = 0;
    issue(mk(OpSh, 32'h2002, 32'hAAAA5555, OpLw, 32'h3000, 32'h0, 1'b1), 3);

    // Squashed store.
    issue(mk(OpSw, 32'h500, 32'h11111111, OpNone, 32'h0, 32'h0, 1'b0), -1);

    // Misaligned LW.
    issue(mk(OpLw, 32'h1, 32'h0, OpNone, 32'h0, 32'h0, 1'b1), 2);

    // Random traffic.
    ack_delay = -1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      else begin
        x.op1 = ops[$urandom_range(0, 10)];
        x.op2 = ops[$urandom_range(0, 10)];
        x.a1 = 32'h4000 + 32'($urandom_range(0, 31));
        x.a2 = 32'h4000 + 32'($urandom_range(0, 31));
        x.r1 = $urandom; x.r2 = $urandom;
        x.cres = ($urandom_range(0, 7) != 0);
        x.rop = 4'($urandom); x.ra1 = 5'($urandom); x.ra2 = 5'($urandom);
        issue(x, -1);
      end
    end

    g = 0;
    while (exp_q.size() > 0 && g < 1000) begin @(negedge clk); g++; end
    check("drain_bundles", 32'(exp_q.size()), 32'd0);
    check("drain_bus_txns", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
